closest_hit_ctrl: RTL and testbench

Sequencer that owns the `intersection` datapath for one ray at a time. It accepts a ray plus a triangle range, streams the triangles from triangle memory into the intersection unit back-to-back, and tracks outstanding requests. It reduces the returned hits to the nearest one (minimum t) and hands a single closest-hit record downstream. It sits between the ray generator and the shading stage.

---
 rtl/closest_hit_ctrl_if.sv | 49 ++++
 rtl/closest_hit_ctrl.sv | 114 +++++++++++
 tb/tb_closest_hit_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/closest_hit_ctrl_if.sv
// Bus bundle between closest_hit_ctrl and its neighbours: ray generator,
// triangle memory, intersection unit and the shading stage.
interface closest_hit_ctrl_if #(
    parameter int TRI_ADDR_W = 12
);
    // Ray request from the ray generator
    logic                        i_ray_valid;
    logic                        o_ray_ready;
    logic [0:1][0:2][31:0]       i_ray;
    logic [TRI_ADDR_W-1:0]       i_tri_base;
    logic [TRI_ADDR_W:0]         i_tri_count;

    // Triangle memory read port, data returns one cycle after the strobe
    logic                        o_mem_rd_en;
    logic [TRI_ADDR_W-1:0]       o_mem_addr;
    logic [0:2][0:2][31:0]       i_mem_rdata;

    // Intersection unit issue and in-order response
    logic                        o_isect_en;
    logic [0:2][0:2][31:0]       o_isect_tri;
    logic [0:1][0:2][31:0]       o_isect_ray;
    logic                        i_isect_valid;
    logic                        i_isect_result;
    logic signed [31:0]          i_isect_t;

    // Closest-hit record towards shading
    logic                        o_hit_valid;
    logic                        i_hit_ready;
    logic                        o_hit;
    logic signed [31:0]          o_hit_t;
    logic [TRI_ADDR_W-1:0]       o_hit_idx;
    logic                        o_err;

    // Controller side
    modport slave (
        input  i_ray_valid, i_ray, i_tri_base, i_tri_count,
        input  i_mem_rdata, i_isect_valid, i_isect_result, i_isect_t, i_hit_ready,
        output o_ray_ready, o_mem_rd_en, o_mem_addr, o_isect_en, o_isect_tri,
        output o_isect_ray, o_hit_valid, o_hit, o_hit_t, o_hit_idx, o_err
    );

    // Environment side
    modport master (
        output i_ray_valid, i_ray, i_tri_base, i_tri_count,
        output i_mem_rdata, i_isect_valid, i_isect_result, i_isect_t, i_hit_ready,
        input  o_ray_ready, o_mem_rd_en, o_mem_addr, o_isect_en, o_isect_tri,
        input  o_isect_ray, o_hit_valid, o_hit, o_hit_t, o_hit_idx, o_err
    );
endinterface

// File: rtl/closest_hit_ctrl.sv
// Per-ray sequencer: streams a triangle range through the intersection unit,
// throttled by an outstanding-request budget, and reduces hits to the nearest.
module closest_hit_ctrl #(
    parameter int TRI_ADDR_W      = 12,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    closest_hit_ctrl_if.slave bus
);
    localparam int CNT_W = TRI_ADDR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state;
    logic [0:1][0:2][31:0]  ray;
    logic [TRI_ADDR_W-1:0]  base;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       resp_cnt;
    logic [OUT_W-1:0]       outstanding;
    logic signed [31:0]     best_t;
    logic [TRI_ADDR_W-1:0]  best_idx;
    logic                   hit;
    logic                   err;
    logic                   isect_en;

    logic rd_en, busy, resp_ok, stray, last_issue, last_resp, closer;

    // Outstanding covers the read in flight as well, so the budget holds
    // before the triangle ever reaches the intersection unit.
    assign rd_en      = (state == ISSUE) && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign busy       = (state == ISSUE) || (state == DRAIN);
    assign resp_ok    = bus.i_isect_valid && busy && (outstanding != '0);
    assign stray      = bus.i_isect_valid && !resp_ok;
    assign last_issue = (issue_cnt == count - CNT_W'(1));
    assign last_resp  = (resp_cnt == count - CNT_W'(1));
    // Strict less-than keeps the lower index on a tie
    assign closer     = bus.i_isect_result && (bus.i_isect_t < best_t);

    assign bus.o_ray_ready = (state == IDLE);
    assign bus.o_mem_rd_en = rd_en;
    assign bus.o_mem_addr  = base + issue_cnt[TRI_ADDR_W-1:0];
    assign bus.o_isect_en  = isect_en;
    assign bus.o_isect_tri = bus.i_mem_rdata;
    assign bus.o_isect_ray = ray;
    assign bus.o_hit_valid = (state == DONE);
    assign bus.o_hit       = hit;
    assign bus.o_hit_t     = best_t;
    assign bus.o_hit_idx   = best_idx;
    assign bus.o_err       = err;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            ray         <= '0;
            base        <= '0;
            count       <= '0;
            issue_cnt   <= '0;
            resp_cnt    <= '0;
            outstanding <= '0;
            best_t      <= 32'sh7FFF_FFFF;
            best_idx    <= '0;
            hit         <= 1'b0;
            err         <= 1'b0;
            isect_en    <= 1'b0;
        end else begin
            isect_en <= rd_en;
            if (stray)
                err <= 1'b1;

            if (rd_en)
                issue_cnt <= issue_cnt + CNT_W'(1);

            case ({rd_en, resp_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (resp_ok) begin
                if (closer) begin
                    best_t   <= bus.i_isect_t;
                    best_idx <= resp_cnt[TRI_ADDR_W-1:0];
                    hit      <= 1'b1;
                end
                resp_cnt <= resp_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.i_ray_valid) begin
                        ray       <= bus.i_ray;
                        base      <= bus.i_tri_base;
                        count     <= bus.i_tri_count;
                        best_t    <= 32'sh7FFF_FFFF;
                        best_idx  <= '0;
                        hit       <= 1'b0;
                        issue_cnt <= '0;
                        resp_cnt  <= '0;
                        state     <= (bus.i_tri_count == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: if (rd_en && last_issue) state <= DRAIN;
                DRAIN: if (resp_ok && last_resp) state <= DONE;
                DONE:  if (bus.i_hit_ready)     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_closest_hit_ctrl.sv
// Directed bench for closest_hit_ctrl with a behavioural triangle memory and
// a fixed-latency intersection unit model driven from per-job response tables.
module tb_closest_hit_ctrl;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    closest_hit_ctrl_if #(.TRI_ADDR_W(AW)) bus ();

    closest_hit_ctrl #(.TRI_ADDR_W(AW), .MAX_OUTSTANDING(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        res;
        logic [31:0] t;
    } resp_t;

    resp_t           resp_tbl[$];
    resp_t           pend_r[$];
    int              pend_due[$];
    logic [AW-1:0]   addr_log[$];
    logic [AW-1:0]   mem_addr_q = '0;
    logic            stray_req  = 1'b0;
    int lat = 3;
    int cyc = 0;
    int rd_cnt = 0, en_cnt = 0, out = 0, max_out = 0;
    int rd_first = -1, rd_last = -1, en_first = -1, en_last = -1, last_v_cyc = -1;

    function automatic logic [0:2][0:2][31:0] build_tri(input logic [AW-1:0] a);
        logic [0:2][0:2][31:0] v;
        v       = '0;
        v[0][0] = 32'hA000_0000 | 32'(a);
        v[2][2] = ~32'(a);
        return v;
    endfunction

    task automatic add_resp(input logic res, input logic [31:0] t);
        resp_tbl.push_back({res, t});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Drive memory data and intersection responses just after the edge
    always @(posedge clk) begin
        #1;
        bus.i_mem_rdata = build_tri(mem_addr_q);
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            bus.i_isect_valid  = 1'b1;
            bus.i_isect_result = pend_r[0].res;
            bus.i_isect_t      = pend_r[0].t;
            void'(pend_due.pop_front());
            void'(pend_r.pop_front());
        end else begin
            bus.i_isect_valid  = stray_req;
            bus.i_isect_result = 1'b0;
            bus.i_isect_t      = '0;
        end
    end

    // Observe DUT mid-cycle; the unit model shares the controller's reset
    always @(negedge clk) begin
        if (rst) begin
            pend_due.delete();
            pend_r.delete();
            out = 0;
        end else begin
            if (bus.o_mem_rd_en) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_last = cyc;
                rd_cnt++;
                addr_log.push_back(bus.o_mem_addr);
                mem_addr_q = bus.o_mem_addr;
                out++;
            end
            if (bus.o_isect_en) begin
                if (en_cnt == 0) en_first = cyc;
                en_last = cyc;
                if (en_cnt < addr_log.size())
                    check("isect_tri", 64'(bus.o_isect_tri[0][0]),
                          64'(32'hA000_0000 | 32'(addr_log[en_cnt])));
                if (en_cnt < resp_tbl.size()) pend_r.push_back(resp_tbl[en_cnt]);
                else                          pend_r.push_back({1'b0, 32'h0});
                pend_due.push_back(cyc + lat);
                en_cnt++;
            end
            if (bus.i_isect_valid) begin
                last_v_cyc = cyc;
                if (out > 0) out--;
            end
            if (out > max_out) max_out = out;
        end
    end

    task automatic reset_checks(input string pfx);
        check({pfx, "_ray_ready"}, bus.o_ray_ready, 1);
        check({pfx, "_rd_en"},     bus.o_mem_rd_en, 0);
        check({pfx, "_isect_en"},  bus.o_isect_en, 0);
        check({pfx, "_hit_valid"}, bus.o_hit_valid, 0);
        check({pfx, "_hit"},       bus.o_hit, 0);
        check({pfx, "_hit_t"},     64'($unsigned(bus.o_hit_t)), 64'h7FFF_FFFF);
        check({pfx, "_hit_idx"},   64'(bus.o_hit_idx), 0);
        check({pfx, "_err"},       bus.o_err, 0);
        check({pfx, "_mem_addr"},  64'(bus.o_mem_addr), 0);
        check({pfx, "_ray_zero"},  64'(bus.o_isect_ray == '0), 1);
    endtask

    task automatic start_job(input logic [AW-1:0] base, input int count, input int l,
                             output int acc);
        @(posedge clk);
        #1;
        lat = l;
        rd_cnt = 0; en_cnt = 0; max_out = 0;
        rd_first = -1; rd_last = -1; en_first = -1; en_last = -1; last_v_cyc = -1;
        addr_log.delete();
        bus.i_ray[0][0] = 32'h0000_0000;
        bus.i_ray[0][1] = 32'h0001_0000;
        bus.i_ray[0][2] = 32'h0001_0000;
        bus.i_ray[1][0] = 32'h0003_0000;
        bus.i_ray[1][1] = 32'h0000_8000;
        bus.i_ray[1][2] = 32'h0001_8000;
        bus.i_tri_base  = base;
        bus.i_tri_count = (AW+1)'(count);
        bus.i_ray_valid = 1'b1;
        acc = cyc;
        @(negedge clk);
        check("ray_ready_idle", bus.o_ray_ready, 1);
        @(posedge clk);
        #1;
        bus.i_ray_valid = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.o_hit_valid) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_seen", bus.o_hit_valid, 1);
    endtask

    task automatic finish_job(input string pfx, input logic exp_hit, input logic [31:0] exp_t,
                              input logic [AW-1:0] exp_idx, input int hold);
        check({pfx, "_hit"},     bus.o_hit, exp_hit);
        check({pfx, "_hit_t"},   64'($unsigned(bus.o_hit_t)), 64'(exp_t));
        check({pfx, "_hit_idx"}, 64'(bus.o_hit_idx), 64'(exp_idx));
        check({pfx, "_err"},     bus.o_err, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({pfx, "_hold_valid"}, bus.o_hit_valid, 1);
            check({pfx, "_hold_t"},     64'($unsigned(bus.o_hit_t)), 64'(exp_t));
            check({pfx, "_hold_ready"}, bus.o_ray_ready, 0);
            check({pfx, "_hold_rd"},    bus.o_mem_rd_en, 0);
        end
        @(posedge clk);
        #1;
        bus.i_hit_ready = 1'b1;
        @(negedge clk);
        check({pfx, "_ready_low_done"}, bus.o_ray_ready, 0);
        @(posedge clk);
        #1;
        bus.i_hit_ready = 1'b0;
        @(negedge clk);
        check({pfx, "_ray_ready_back"}, bus.o_ray_ready, 1);
        check({pfx, "_valid_drop"},     bus.o_hit_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, done;
        bus.i_ray_valid = 1'b0;
        bus.i_ray       = '0;
        bus.i_tri_base  = '0;
        bus.i_tri_count = '0;
        bus.i_hit_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks("rst");

        // Single triangle
        resp_tbl.delete();
        add_resp(1'b1, 32'h0002_C000);
        start_job(12'h010, 1, 3, acc);
        check("j1_ray_reg", 64'(bus.o_isect_ray[1][0]), 64'h0003_0000);
        wait_done(done);
        check("j1_done_cyc", done, acc + 6);
        check("j1_rd_first", rd_first, acc + 1);
        check("j1_rd_cnt",   rd_cnt, 1);
        check("j1_en_first", en_first, acc + 2);
        check("j1_addr",     64'(addr_log[0]), 64'h010);
        finish_job("j1", 1'b1, 32'h0002_C000, 12'h000, 0);

        // Empty job
        resp_tbl.delete();
        start_job(12'h123, 0, 3, acc);
        wait_done(done);
        check("j2_done_cyc", done, acc + 1);
        check("j2_rd_cnt",   rd_cnt, 0);
        finish_job("j2", 1'b0, 32'h7FFF_FFFF, 12'h000, 0);

        // A hit at the maximum t never beats the initial best
        resp_tbl.delete();
        add_resp(1'b1, 32'h7FFF_FFFF);
        start_job(12'h200, 1, 2, acc);
        wait_done(done);
        finish_job("j3", 1'b0, 32'h7FFF_FFFF, 12'h000, 0);

        // Reduction with a tie, a miss, and address wrap
        resp_tbl.delete();
        add_resp(1'b1, 32'h0005_0000);
        add_resp(1'b1, 32'h0002_C000);
        add_resp(1'b1, 32'h0002_C000);
        add_resp(1'b0, 32'h0000_0100);
        start_job(12'hFFE, 4, 5, acc);
        wait_done(done);
        check("j4_addr0",    64'(addr_log[0]), 64'hFFE);
        check("j4_addr1",    64'(addr_log[1]), 64'hFFF);
        check("j4_addr2",    64'(addr_log[2]), 64'h000);
        check("j4_addr3",    64'(addr_log[3]), 64'h001);
        check("j4_en_cnt",   en_cnt, 4);
        check("j4_latency",  done, last_v_cyc + 1);
        finish_job("j4", 1'b1, 32'h0002_C000, 12'h001, 0);

        // Negative t wins under signed compare; back-to-back issue timing
        resp_tbl.delete();
        add_resp(1'b1, 32'h0001_0000);
        add_resp(1'b1, 32'hFFFF_8000);
        start_job(12'h300, 2, 5, acc);
        wait_done(done);
        check("j5_rd_first", rd_first, acc + 1);
        check("j5_rd_last",  rd_last, acc + 2);
        check("j5_en_first", en_first, acc + 2);
        check("j5_en_last",  en_last, acc + 3);
        check("j5_done_cyc", done, acc + 9);
        finish_job("j5", 1'b1, 32'hFFFF_8000, 12'h001, 0);

        // Throttled job followed by downstream backpressure
        resp_tbl.delete();
        add_resp(1'b1, 32'h0004_0000);
        add_resp(1'b1, 32'h0003_0000);
        add_resp(1'b1, 32'h0005_0000);
        add_resp(1'b1, 32'h0002_0000);
        add_resp(1'b1, 32'h0002_0000);
        add_resp(1'b1, 32'h0006_0000);
        start_job(12'h400, 6, 8, acc);
        wait_done(done);
        check("j6_max_out_le2", 64'(max_out <= 2), 1);
        check("j6_max_out",     max_out, 2);
        check("j6_rd_gaps",     64'((rd_last - rd_first + 1) > 6), 1);
        check("j6_rd_cnt",      rd_cnt, 6);
        check("j6_en_cnt",      en_cnt, 6);
        finish_job("j6", 1'b1, 32'h0002_0000, 12'h003, 20);

        // Reset in the middle of issuing
        resp_tbl.delete();
        for (int i = 0; i < 8; i++) add_resp(1'b1, 32'h0001_0000 + 32'(i));
        start_job(12'h040, 8, 8, acc);
        for (int i = 0; i < 100; i++) begin
            if (rd_cnt >= 3) break;
            @(negedge clk);
        end
        check("j7_reached_3", rd_cnt, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks("j7_rst");

        resp_tbl.delete();
        add_resp(1'b1, 32'h0002_C000);
        start_job(12'h010, 1, 3, acc);
        wait_done(done);
        check("j8_done_cyc", done, acc + 6);
        finish_job("j8", 1'b1, 32'h0002_C000, 12'h000, 0);

        // Stray response in IDLE sets the sticky error and is otherwise ignored
        @(negedge clk);
        stray_req = 1'b1;
        @(negedge clk);
        stray_req = 1'b0;
        @(negedge clk);
        check("err_set",       bus.o_err, 1);
        check("err_no_valid",  bus.o_hit_valid, 0);
        check("err_ray_ready", bus.o_ray_ready, 1);
        repeat (3) @(negedge clk);
        check("err_sticky",    bus.o_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end
endmodule
